mem_port_arbiter: RTL and testbench

Shares the core's single memory bus between the instruction-fetch stage (read-only) and the memory-access stage (read/write). One transaction is outstanding at a time. Data accesses have priority, with a fetch-starvation guard and a transaction timeout. The per-stage stall outputs are consumed by the pipeline registers between stages.

---
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory bus between instruction fetch and data access.
// Single outstanding transaction, data priority with a fetch-starvation guard and a timeout.
module mem_port_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic [DW-1:0]   if_rdata_o,
  output logic            if_done_o,
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [AW-1:0]   mem_addr_i,
  input  logic [DW-1:0]   mem_wdata_i,
  input  logic [DW/8-1:0] mem_wmask_i,
  output logic [DW-1:0]   mem_rdata_o,
  output logic            mem_done_o,
  output logic            bus_valid_o,
  input  logic            bus_ready_i,
  output logic            bus_we_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW-1:0]   bus_wdata_o,
  output logic [DW/8-1:0] bus_wmask_o,
  input  logic            bus_rvalid_i,
  input  logic [DW-1:0]   bus_rdata_i,
  output logic            stall_if_o,
  output logic            stall_mem_o,
  output logic            timeout_o
);

  // state  | meaning
  // S_IDLE | no transaction; arbitrate pending requests
  // S_ADDR | request presented on the bus, waiting for bus_ready_i
  // S_RESP | request accepted, waiting for bus_rvalid_i
  // S_DONE | owner's done pulse; requests not sampled

  localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TMO_LOAD   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_t;

  state_t          state, state_nxt;
  logic            owner_if;
  logic [SW-1:0]   streak;
  logic [TW-1:0]   tmo_cnt;
  logic            grant_if, grant_mem, tmo_hit, resp_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    grant_mem = mem_req_i && !(if_req_i && (streak == STREAK_MAX));
    grant_if  = if_req_i && !grant_mem;
    // Down-counter hits zero in the TIMEOUT-th cycle spent in ADDR+RESP.
    tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == '0);
    resp_ok   = (state == S_RESP) && bus_rvalid_i;
    state_nxt = state;
    case (state)
      S_IDLE: if (grant_if || grant_mem) state_nxt = S_ADDR;
      S_ADDR: begin
        if (tmo_hit)                         state_nxt = S_DONE;
        else if (bus_valid_o && bus_ready_i) state_nxt = S_RESP;
      end
      S_RESP: if (bus_rvalid_i || tmo_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_if    <= 1'b0;
      streak      <= '0;
      tmo_cnt     <= '0;
      bus_valid_o <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wmask_o <= '0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      bus_valid_o <= (state_nxt == S_ADDR);
      if_done_o   <= (state_nxt == S_DONE) && owner_if;
      mem_done_o  <= (state_nxt == S_DONE) && !owner_if;

      if (state == S_IDLE && state_nxt == S_ADDR) begin
        owner_if    <= grant_if;
        tmo_cnt     <= TMO_LOAD;
        bus_we_o    <= grant_if ? 1'b0 : mem_we_i;
        bus_addr_o  <= grant_if ? if_addr_i : mem_addr_i;
        bus_wdata_o <= grant_if ? '0 : mem_wdata_i;
        bus_wmask_o <= grant_if ? '0 : mem_wmask_i;
        if (grant_if)
          streak <= '0;
        else if (if_req_i && streak != STREAK_MAX)
          streak <= streak + 1'b1;
      end else if ((state == S_ADDR || state == S_RESP) && !tmo_hit) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end

      // A response in the terminal cycle still counts as a normal completion.
      if (state != S_DONE && state_nxt == S_DONE) begin
        if (owner_if) if_rdata_o  <= resp_ok ? bus_rdata_i : '0;
        else          mem_rdata_o <= resp_ok ? bus_rdata_i : '0;
        if (!resp_ok) timeout_o <= 1'b1;
      end
    end
  end

  assign stall_if_o  = if_req_i && !if_done_o;
  assign stall_mem_o = mem_req_i && !mem_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model checked every
// cycle plus directed scenarios with hand-computed latencies and data.
module tb_mem_port_arbiter;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_done_o;
  logic          mem_req_i = 1'b0;
  logic          mem_we_i = 1'b0;
  logic [AW-1:0] mem_addr_i = '0;
  logic [DW-1:0] mem_wdata_i = '0;
  logic [7:0]    mem_wmask_i = '0;
  logic [DW-1:0] mem_rdata_o;
  logic          mem_done_o;
  logic          bus_valid_o;
  logic          bus_ready_i = 1'b0;
  logic          bus_we_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [7:0]    bus_wmask_o;
  logic          bus_rvalid_i = 1'b0;
  logic [DW-1:0] bus_rdata_i = '0;
  logic          stall_if_o;
  logic          stall_mem_o;
  logic          timeout_o;

  int errors = 0;
  int checks = 0;

  // bus responder knobs, written by the stimulus process only
  int            ready_delay = 0;
  bit            resp_en = 1'b1;
  logic [DW-1:0] resp_data = '0;
  bit            late_pulse = 1'b0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wmask_i(mem_wmask_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wmask_o(bus_wmask_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Bus slave: ready after ready_delay ADDR cycles, response the cycle after acceptance.
  bit last_valid = 1'b0;
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bus_ready_i  = 1'b0;
      bus_rvalid_i = 1'b0;
      last_valid   = 1'b0;
      wcnt         = 0;
    end else begin
      bus_rvalid_i = (resp_en && last_valid && bus_ready_i) || late_pulse;
      bus_rdata_i  = resp_data;
      if (bus_valid_o) begin
        bus_ready_i = (wcnt >= ready_delay);
        wcnt++;
      end else begin
        bus_ready_i = 1'b0;
        wcnt        = 0;
      end
      last_valid = bus_valid_o;
    end
  end

  // Transaction-level model: what the outputs must be this cycle, then what the
  // next edge does to the transaction given the inputs seen now.
  bit            m_fly = 0, m_resp = 0, m_done = 0, m_own_if = 0, m_tmo = 0, m_we = 0;
  int            m_age = 0, m_streak = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  logic [7:0]    m_wmask = '0;

  always @(negedge clk) begin
    bit pick_if;
    if (!rst_n) begin
      m_fly = 0; m_resp = 0; m_done = 0; m_own_if = 0; m_tmo = 0; m_streak = 0;
    end
    chk("bus_valid", bus_valid_o, m_fly && !m_resp);
    if (m_fly) begin
      chk("bus_addr", bus_addr_o, m_addr);
      chk("bus_we", bus_we_o, m_we);
      chk("bus_wmask", bus_wmask_o, m_wmask);
      if (!m_own_if) chk("bus_wdata", bus_wdata_o, m_wdata);
    end
    chk("if_done", if_done_o, m_done && m_own_if);
    chk("mem_done", mem_done_o, m_done && !m_own_if);
    if (m_done && m_own_if)  chk("if_rdata", if_rdata_o, m_rdata);
    if (m_done && !m_own_if) chk("mem_rdata", mem_rdata_o, m_rdata);
    chk("timeout", timeout_o, m_tmo);
    chk("stall_if", stall_if_o, if_req_i && !(m_done && m_own_if));
    chk("stall_mem", stall_mem_o, mem_req_i && !(m_done && !m_own_if));

    if (rst_n) begin
      if (m_done) begin
        m_done = 0;
      end else if (m_fly) begin
        if (m_resp && bus_rvalid_i) begin
          m_rdata = bus_rdata_i; m_fly = 0; m_done = 1;
        end else if (TMO != 0 && m_age == TMO) begin
          m_rdata = '0; m_tmo = 1; m_fly = 0; m_done = 1;
        end else begin
          if (!m_resp && bus_ready_i) m_resp = 1;
          m_age++;
        end
      end else if (if_req_i || mem_req_i) begin
        pick_if = if_req_i && (!mem_req_i || m_streak == MAXS);
        m_own_if = pick_if;
        if (pick_if) begin
          m_streak = 0;
          m_addr = if_addr_i; m_we = 0; m_wmask = '0; m_wdata = '0;
        end else begin
          if (if_req_i && m_streak < MAXS) m_streak++;
          m_addr = mem_addr_i; m_we = mem_we_i; m_wmask = mem_wmask_i; m_wdata = mem_wdata_i;
        end
        m_fly = 1; m_resp = 0; m_age = 1;
      end
    end
  end

  task automatic wait_done(input int budget, output int lat, output int vcnt, output bit wif);
    bit seen = 0;
    lat = 0; vcnt = 0; wif = 0;
    while (!seen && lat < budget) begin
      tick();
      lat++;
      if (bus_valid_o) vcnt++;
      if (if_done_o || mem_done_o) begin
        seen = 1;
        wif  = if_done_o;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int lat, vcnt;
    bit wif;
    logic [9:0] order;

    repeat (3) tick();
    chk("rst_valid", bus_valid_o, 0);
    chk("rst_if_done", if_done_o, 0);
    chk("rst_mem_done", mem_done_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_stall_if", stall_if_o, 0);
    rst_n = 1'b1;
    tick();

    // single fetch, best case
    resp_en = 1; ready_delay = 0; resp_data = 64'h13;
    if_req_i = 1; if_addr_i = 64'h8000_0000;
    wait_done(10, lat, vcnt, wif);
    chk("t1_latency", lat, 3);
    chk("t1_valid_cycles", vcnt, 1);
    chk("t1_owner_if", wif, 1);
    chk("t1_rdata", if_rdata_o, 64'h13);
    chk("t1_stall_if_done", stall_if_o, 0);
    if_req_i = 0;
    tick();

    // write with 3 cycles of backpressure
    ready_delay = 3; resp_data = 64'h0;
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 64'h8000_1000;
    mem_wdata_i = 64'hDEAD_BEEF; mem_wmask_i = 8'h0F;
    wait_done(20, lat, vcnt, wif);
    chk("t2_latency", lat, 6);
    chk("t2_valid_cycles", vcnt, 4);
    chk("t2_owner_mem", wif, 0);
    chk("t2_stall_mem_done", stall_mem_o, 0);
    mem_req_i = 0; mem_we_i = 0;
    tick();
    chk("t2_single_pulse", mem_done_o, 0);

    // response arrives in the timeout terminal cycle: normal completion
    ready_delay = 6; resp_data = 64'hCAFE;
    mem_req_i = 1; mem_addr_i = 64'h4000; mem_wmask_i = 8'h00;
    wait_done(20, lat, vcnt, wif);
    chk("t2b_latency", lat, 9);
    chk("t2b_valid_cycles", vcnt, 7);
    chk("t2b_rdata", mem_rdata_o, 64'hCAFE);
    chk("t2b_no_timeout", timeout_o, 0);
    mem_req_i = 0;
    tick();

    // contention: both held continuously
    ready_delay = 0; resp_data = 64'h77;
    if_req_i = 1; if_addr_i = 64'h1000;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 64'h2000;
    order = '0;
    for (int k = 0; k < 10; k++) begin
      wait_done(10, lat, vcnt, wif);
      order[k] = wif;
      chk("t3_latency", lat, (k == 0) ? 3 : 4);
    end
    if_req_i = 0; mem_req_i = 0;
    chk("t3_grant_order", order, 10'h210);
    tick();

    // timeout: no response ever
    resp_en = 0; ready_delay = 0;
    if_req_i = 1; if_addr_i = 64'h3000;
    wait_done(20, lat, vcnt, wif);
    chk("t4_latency", lat, TMO + 1);
    chk("t4_rdata_zero", if_rdata_o, 0);
    chk("t4_timeout_set", timeout_o, 1);
    if_req_i = 0;
    repeat (3) tick();
    chk("t4_timeout_sticky", timeout_o, 1);
    late_pulse = 1;
    tick();
    late_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_late_no_done", if_done_o | mem_done_o, 0);
    end
    chk("t4_timeout_still", timeout_o, 1);

    // normal read after a timeout
    resp_en = 1; resp_data = 64'h55;
    mem_req_i = 1; mem_addr_i = 64'h5000;
    wait_done(10, lat, vcnt, wif);
    chk("t4b_latency", lat, 3);
    chk("t4b_rdata", mem_rdata_o, 64'h55);
    mem_req_i = 0;
    tick();

    // reset during RESP
    resp_en = 0;
    if_req_i = 1; if_addr_i = 64'h6000;
    tick();
    tick();
    #1 rst_n = 0;
    #1;
    chk("t5_valid", bus_valid_o, 0);
    chk("t5_if_done", if_done_o, 0);
    chk("t5_timeout", timeout_o, 0);
    chk("t5_addr", bus_addr_o, 0);
    chk("t5_mem_rdata", mem_rdata_o, 0);
    if_req_i = 0;
    tick();
    tick();
    rst_n = 1;
    resp_en = 1; resp_data = 64'h99;
    if_req_i = 1; if_addr_i = 64'h8000_0040;
    wait_done(10, lat, vcnt, wif);
    chk("t5_fresh_latency", lat, 3);
    chk("t5_fresh_owner", wif, 1);
    chk("t5_fresh_rdata", if_rdata_o, 64'h99);
    if_req_i = 0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
